// File: rtl/mixer_ddc_decim_acc_if.sv
// Valid/ready stream carrying one signed I/Q pair per transfer.
interface mixer_ddc_decim_acc_if #(
    parameter int unsigned W = 24
);
    logic                valid;
    logic                ready;
    logic signed [W-1:0] i;
    logic signed [W-1:0] q;

    modport master (output valid, output i, output q, input ready);
    modport slave  (input valid, input i, input q, output ready);
endinterface

// File: rtl/mixer_ddc_decim_acc.sv
// Integrate-and-dump I/Q decimator with round, shift, saturate and a valid/ready output register.
// Optional saturation event counter: define MIXER_DDC_DECIM_SATCNT_EN.
module mixer_ddc_decim_acc #(
    parameter int unsigned IN_W       = 24,
    parameter int unsigned OUT_W      = 16,
    parameter int unsigned DECIM_LOG2 = 2,
    parameter int unsigned SHIFT      = 10
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         ce,
    input  logic                         sync,
    mixer_ddc_decim_acc_if.slave         in_s,
    mixer_ddc_decim_acc_if.master        out_m,
    output logic                         sat_flag,
    output logic [15:0]                  sat_cnt
);
    localparam int unsigned ACC_W = IN_W + DECIM_LOG2 + 1;
    // Wide values carry one guard bit so the rounding offset can never wrap.
    localparam logic signed [ACC_W:0] RND =
        (SHIFT == 0) ? '0 : ((ACC_W + 1)'(1) << ((SHIFT == 0) ? 0 : SHIFT - 1));
    localparam logic signed [ACC_W:0] SAT_HI = {{(ACC_W - OUT_W + 2){1'b0}}, {(OUT_W - 1){1'b1}}};
    localparam logic signed [ACC_W:0] SAT_LO = ~SAT_HI;

    logic signed [ACC_W-1:0]  acc_i, acc_q;
    logic [DECIM_LOG2-1:0]    cnt;
    logic signed [OUT_W-1:0]  out_i_r, out_q_r;
    logic                     out_valid_r;

    logic                     accept, pop, dump, hit_i, hit_q;
    logic signed [ACC_W:0]    s_i, s_q, r_i, r_q;
    logic signed [OUT_W-1:0]  o_i, o_q;

    assign in_s.ready  = ce & (~out_valid_r | out_m.ready);
    assign accept      = in_s.valid & in_s.ready;
    assign pop         = ce & out_valid_r & out_m.ready;
    // A sync-accept starts a new frame, so it never dumps.
    assign dump        = accept & ~sync & (cnt == '1);

    assign out_m.valid = out_valid_r;
    assign out_m.i     = out_i_r;
    assign out_m.q     = out_q_r;

    always_comb begin
        s_i   = acc_i + in_s.i;
        s_q   = acc_q + in_s.q;
        r_i   = (s_i + RND) >>> SHIFT;
        r_q   = (s_q + RND) >>> SHIFT;
        hit_i = (r_i > SAT_HI) || (r_i < SAT_LO);
        hit_q = (r_q > SAT_HI) || (r_q < SAT_LO);
        o_i   = r_i[OUT_W-1:0];
        o_q   = r_q[OUT_W-1:0];
        if (r_i > SAT_HI) o_i = SAT_HI[OUT_W-1:0];
        else if (r_i < SAT_LO) o_i = SAT_LO[OUT_W-1:0];
        if (r_q > SAT_HI) o_q = SAT_HI[OUT_W-1:0];
        else if (r_q < SAT_LO) o_q = SAT_LO[OUT_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_i       <= '0;
            acc_q       <= '0;
            cnt         <= '0;
            out_i_r     <= '0;
            out_q_r     <= '0;
            out_valid_r <= 1'b0;
            sat_flag    <= 1'b0;
        end else if (ce) begin
            if (sync) begin
                acc_i <= accept ? ACC_W'(in_s.i) : '0;
                acc_q <= accept ? ACC_W'(in_s.q) : '0;
                cnt   <= accept ? DECIM_LOG2'(1) : '0;
            end else if (accept) begin
                if (cnt == '1) begin
                    acc_i <= '0;
                    acc_q <= '0;
                    cnt   <= '0;
                end else begin
                    acc_i <= s_i[ACC_W-1:0];
                    acc_q <= s_q[ACC_W-1:0];
                    cnt   <= cnt + DECIM_LOG2'(1);
                end
            end
            if (dump) begin
                out_i_r     <= o_i;
                out_q_r     <= o_q;
                out_valid_r <= 1'b1;
                if (hit_i || hit_q) sat_flag <= 1'b1;
            end else if (pop) begin
                out_valid_r <= 1'b0;
            end
        end
    end

`ifdef MIXER_DDC_DECIM_SATCNT_EN
    logic [15:0] sat_cnt_r;

    always_ff @(posedge clk) begin
        if (reset) begin
            sat_cnt_r <= '0;
        end else if (dump && (hit_i || hit_q) && (sat_cnt_r != 16'hFFFF)) begin
            sat_cnt_r <= sat_cnt_r + 16'd1;
        end
    end

    assign sat_cnt = sat_cnt_r;
`else
    assign sat_cnt = 16'h0000;
`endif
endmodule
